// File: rtl/io_pattern_selftest.sv
// Pin-level pattern generator with optional fixed-latency loopback checker.
// After a run, uo_out reports a saturating mismatch count.
`timescale 1ns/1ps
module io_pattern_selftest #(
  parameter int              WIDTH     = 8,
  parameter int              RUN_LEN   = 256,
  parameter int              LOOP_LAT  = 2,
  parameter logic [WIDTH-1:0] LFSR_SEED = WIDTH'(8'h01),
  parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(8'hB8)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [7:0]       ui_in,
  output logic [WIDTH-1:0] uo_out,
  input  logic [WIDTH-1:0] uio_in,
  output logic [WIDTH-1:0] uio_out,
  output logic [WIDTH-1:0] uio_oe
);

  localparam int CW = (RUN_LEN > 8) ? $clog2(RUN_LEN) : 3;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  state_t           state_r, state_s;
  logic             start_q_r;
  logic [1:0]       mode_r, mode_s;
  logic             chk_r, chk_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic [WIDTH-1:0] lfsr_r, lfsr_s;
  logic [WIDTH-1:0] out_r, out_s;
  logic [WIDTH-1:0] err_r, err_s, err_sat_s;
  logic [WIDTH-1:0] exp_s;
  logic             exp_vld_s;
  logic             start_s, abort_s, miss_s, clr_pipe_s;
  logic             unused_s;

  function automatic logic [WIDTH-1:0] lfsr_next_f(input logic [WIDTH-1:0] p);
    logic [WIDTH-1:0] n;
    n    = p << 1'b1;
    n[0] = ^(p & LFSR_TAPS);
    return n;
  endfunction

  function automatic logic [WIDTH-1:0] pat_f(input logic [1:0] m, input logic [CW-1:0] k,
                                             input logic [WIDTH-1:0] lf);
    logic [31:0]      kk;
    logic [WIDTH-1:0] p;
    kk = 32'(k);
    p  = {WIDTH{1'b0}};
    case (m)
      2'b00: p = kk[WIDTH-1:0];
      2'b01: begin
        for (int i = 0; i < WIDTH; i++) p[i] = (32'(i) == (kk % 32'(WIDTH)));
      end
      2'b10: p = lf;
      default: begin
        for (int i = 0; i < WIDTH; i++) p[i] = ((i % 2) == 0) != kk[0];
      end
    endcase
    return p;
  endfunction

  assign start_s   = ui_in[2] & ~start_q_r;
  assign abort_s   = ui_in[4] & ((state_r == RUN) || (state_r == DRAIN));
  assign miss_s    = chk_r && exp_vld_s && (exp_s != uio_in) &&
                     ((state_r == RUN) || (state_r == DRAIN));
  assign err_sat_s = (miss_s && (err_r != {WIDTH{1'b1}})) ? err_r + WIDTH'(1'b1) : err_r;
  assign unused_s  = ^ui_in[7:5];

  assign uo_out  = out_r;
  assign uio_out = {WIDTH{1'b0}};
  assign uio_oe  = {WIDTH{1'b0}};

  // Expected-value delay line: each entry is tagged valid only when sent during RUN.
  if (LOOP_LAT == 0) begin : g_nolat
    assign exp_s     = out_r;
    assign exp_vld_s = (state_r == RUN);
  end else begin : g_lat
    logic [WIDTH-1:0]    dly_r [LOOP_LAT];
    logic [LOOP_LAT-1:0] vld_r;

    // Shift sent patterns toward the loopback sample point.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_r <= {LOOP_LAT{1'b0}};
        for (int i = 0; i < LOOP_LAT; i++) dly_r[i] <= {WIDTH{1'b0}};
      end else if (ena) begin
        vld_r[0] <= (state_r == RUN) && !clr_pipe_s;
        dly_r[0] <= out_r;
        for (int i = 1; i < LOOP_LAT; i++) begin
          vld_r[i] <= vld_r[i-1] && !clr_pipe_s;
          dly_r[i] <= dly_r[i-1];
        end
      end
    end

    assign exp_s     = dly_r[LOOP_LAT-1];
    assign exp_vld_s = vld_r[LOOP_LAT-1];
  end

  // Next-state and next-output logic for the run sequencer.
  always_comb begin
    state_s    = state_r;
    mode_s     = mode_r;
    chk_s      = chk_r;
    cnt_s      = cnt_r;
    lfsr_s     = lfsr_r;
    out_s      = {WIDTH{1'b0}};
    err_s      = err_sat_s;
    clr_pipe_s = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (state_r == DONE) begin
          out_s = err_r;
        end else begin
          out_s = {WIDTH{1'b0}};
        end
        if (start_s) begin
          state_s    = RUN;
          mode_s     = ui_in[1:0];
          chk_s      = ui_in[3];
          cnt_s      = {CW{1'b0}};
          lfsr_s     = LFSR_SEED;
          err_s      = {WIDTH{1'b0}};
          clr_pipe_s = 1'b1;
          out_s      = pat_f(ui_in[1:0], {CW{1'b0}}, LFSR_SEED);
        end else begin
          state_s = state_r;
        end
      end
      RUN: begin
        if (abort_s) begin
          state_s    = IDLE;
          cnt_s      = {CW{1'b0}};
          err_s      = {WIDTH{1'b0}};
          clr_pipe_s = 1'b1;
        end else if (cnt_r == CW'(RUN_LEN - 1)) begin
          cnt_s = {CW{1'b0}};
          if (LOOP_LAT == 0) begin
            state_s = DONE;
            out_s   = err_sat_s;
          end else begin
            state_s = DRAIN;
          end
        end else begin
          cnt_s  = cnt_r + CW'(1'b1);
          lfsr_s = lfsr_next_f(lfsr_r);
          out_s  = pat_f(mode_r, cnt_r + CW'(1'b1), lfsr_next_f(lfsr_r));
        end
      end
      DRAIN: begin
        if (abort_s) begin
          state_s    = IDLE;
          cnt_s      = {CW{1'b0}};
          err_s      = {WIDTH{1'b0}};
          clr_pipe_s = 1'b1;
        end else if (cnt_r == CW'(LOOP_LAT - 1)) begin
          state_s = DONE;
          cnt_s   = {CW{1'b0}};
          out_s   = err_sat_s;
        end else begin
          cnt_s = cnt_r + CW'(1'b1);
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Sequencer and datapath registers; ena=0 freezes everything, including start history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      start_q_r <= 1'b0;
      mode_r    <= 2'b00;
      chk_r     <= 1'b0;
      cnt_r     <= {CW{1'b0}};
      lfsr_r    <= {WIDTH{1'b0}};
      out_r     <= {WIDTH{1'b0}};
      err_r     <= {WIDTH{1'b0}};
    end else if (ena) begin
      state_r   <= state_s;
      start_q_r <= ui_in[2];
      mode_r    <= mode_s;
      chk_r     <= chk_s;
      cnt_r     <= cnt_s;
      lfsr_r    <= lfsr_s;
      out_r     <= out_s;
      err_r     <= err_s;
    end
  end

endmodule

// File: tb/tb_io_pattern_selftest.sv
// Directed bench for io_pattern_selftest: external 2-cycle loopback, pattern,
// error-count, abort, reset and ena-gating checks.
`timescale 1ns/1ps
module tb_io_pattern_selftest;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uo_out, uio_in, uio_out, uio_oe;
  logic [7:0] lb1 = 8'h00, lb2 = 8'h00, flip = 8'h00;
  logic [7:0] seen4 = 8'h00, seen255 = 8'h00;
  int         total = 0;
  int         bad = 0;

  io_pattern_selftest dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  // External loopback: uo_out reappears on uio_in two enabled cycles later.
  always @(posedge clk) begin
    if (ena) begin
      lb1 <= uo_out;
      lb2 <= lb1;
    end
  end
  assign uio_in = lb2 ^ flip;

  initial begin
    #1000000;
    $display("FAIL watchdog: no finish by 1ms");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%02h expected=%02h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] exp_pat(input logic [1:0] m, input int k, input logic [7:0] lf);
    logic [7:0] kb;
    kb = k[7:0];
    case (m)
      2'b00:   return kb;
      2'b01:   return 8'h01 << (k % 8);
      2'b10:   return lf;
      default: return (k % 2 == 1) ? 8'hAA : 8'h55;
    endcase
  endfunction

  // Start edge, then scramble mode/check_en (must be ignored mid-run).
  task automatic start_run(input logic [1:0] m, input logic ce, input logic hold);
    @(negedge clk);
    ui_in = {3'b111, 1'b0, ce, 1'b1, m};
    @(negedge clk);
    ui_in = {3'b000, 1'b0, ~ce, hold, ~m};
  endtask

  task automatic run(input string tag, input logic [1:0] m, input logic ce, input logic inv,
                     input int inj0, input int inj1, input int inj2, input int stall_k,
                     input logic hold, input logic [7:0] done_exp);
    logic [7:0] lf;
    lf = 8'h01;
    flip = inv ? 8'hFF : 8'h00;
    start_run(m, ce, hold);
    for (int k = 0; k < 256; k++) begin
      if (k > 0) @(negedge clk);
      flip = inv ? 8'hFF : 8'h00;
      if (k == inj0 || k == inj1 || k == inj2) flip = flip ^ 8'h01;
      chk({tag, "_pat"}, uo_out, exp_pat(m, k, lf));
      if (k == 4) seen4 = uo_out;
      if (k == 255) seen255 = uo_out;
      if (k == stall_k) begin
        ena = 1'b0;
        for (int s = 0; s < 10; s++) begin
          @(negedge clk);
          chk({tag, "_hold"}, uo_out, exp_pat(m, k, lf));
        end
        ena = 1'b1;
      end
      lf = {lf[6:0], ^(lf & 8'hB8)};
    end
    @(negedge clk);
    flip = inv ? 8'hFF : 8'h00;
    chk({tag, "_drain0"}, uo_out, 8'h00);
    @(negedge clk);
    chk({tag, "_drain1"}, uo_out, 8'h00);
    @(negedge clk);
    chk({tag, "_done"}, uo_out, done_exp);
    @(negedge clk);
    chk({tag, "_done_hold"}, uo_out, done_exp);
    flip = 8'h00;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_uo", uo_out, 8'h00);
    chk("rst_uio_oe", uio_oe, 8'h00);
    chk("rst_uio_out", uio_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    ena   = 1'b1;
    @(negedge clk);
    chk("idle_uo", uo_out, 8'h00);

    run("cnt", 2'b00, 1'b1, 1'b0, -1, -1, -1, -1, 1'b0, 8'h00);
    chk("run_uio_oe", uio_oe, 8'h00);
    run("walk_nochk", 2'b01, 1'b0, 1'b1, -1, -1, -1, -1, 1'b0, 8'h00);
    run("checker", 2'b11, 1'b1, 1'b0, -1, -1, -1, -1, 1'b0, 8'h00);
    run("lfsr", 2'b10, 1'b1, 1'b0, -1, -1, -1, -1, 1'b0, 8'h00);
    chk("lfsr_p4", seen4, 8'h11);
    chk("lfsr_p255", seen255, 8'h01);
    run("inj3", 2'b00, 1'b1, 1'b0, 10, 50, 200, -1, 1'b0, 8'h03);
    run("inv_sat", 2'b00, 1'b1, 1'b1, -1, -1, -1, -1, 1'b0, 8'hFF);

    // Abort at k=100 with a simultaneous start request
    flip = 8'hFF;
    start_run(2'b00, 1'b1, 1'b0);
    for (int k = 1; k <= 100; k++) @(negedge clk);
    chk("abort_k100", uo_out, 8'd100);
    ui_in = 8'h14;
    @(negedge clk);
    chk("abort_idle", uo_out, 8'h00);
    ui_in = 8'h00;
    flip  = 8'h00;
    @(negedge clk);
    chk("abort_idle_hold", uo_out, 8'h00);
    run("post_abort", 2'b00, 1'b1, 1'b0, -1, -1, -1, -1, 1'b0, 8'h00);

    // Asynchronous reset mid-run
    start_run(2'b00, 1'b1, 1'b0);
    for (int k = 1; k <= 50; k++) @(negedge clk);
    chk("pre_rst_k50", uo_out, 8'h32);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", uo_out, 8'h00);
    @(negedge clk);
    ui_in = 8'h00;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", uo_out, 8'h00);

    // ena stall mid-run with start held high throughout
    run("ena_stall", 2'b00, 1'b1, 1'b0, -1, -1, -1, 20, 1'b1, 8'h00);
    @(negedge clk);
    chk("no_restart0", uo_out, 8'h00);
    @(negedge clk);
    chk("no_restart1", uo_out, 8'h00);
    ui_in = 8'h00;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/io_pattern_selftest.md
Name: io_pattern_selftest

Overview:
- Parametrised on-silicon successor to the top-level harness used for bring-up of the fountaincoder designs.
- Generates a selectable test pattern on uo_out and optionally checks the pattern looped back externally into uio_in with a fixed latency.
- After a run, reports a saturating error count on uo_out, so the chip can be exercised on the demo board without a cocotb bench.

Parameters:
WIDTH, 8, pattern/pin bus width (1..8 when mapped to TT pins)
RUN_LEN, 256, pattern cycles per run (>=1)
LOOP_LAT, 2, cycles from uo_out to matching uio_in sample (0..7)
LFSR_SEED, 8'h01, LFSR start value (WIDTH bits, nonzero)
LFSR_TAPS, 8'hB8, XOR tap mask for LFSR feedback

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  clock enable; 0 freezes all state
ui_in  in  8  [1:0] mode, [2] start, [3] check_en, [4] abort, [7:5] unused
uo_out  out  WIDTH  pattern during run, error count when done
uio_in  in  WIDTH  loopback return
uio_out  out  WIDTH  constant 0
uio_oe  out  WIDTH  constant 0 (all pins inputs)

Behaviour:
- Reset (async, rst_n=0): state IDLE, uo_out=0, err_cnt=0, cycle counter=0, delay/valid pipeline cleared, start-edge register=0.
- All registers update only when ena=1. With ena=0, everything holds, including the start-edge history.
- Start is the rising edge of ui_in[2]: start_q captures the previous value, and the edge is ui_in[2] & ~start_q.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: uo_out=0. A start edge latches mode and check_en, loads the pattern seed, clears err_cnt and the counter, and moves to RUN.
- RUN: uo_out is a registered P(k) for k=0..RUN_LEN-1, with the first RUN cycle carrying P(0). When k=RUN_LEN-1, go to DRAIN.
- DRAIN: lasts LOOP_LAT cycles with uo_out=0, then DONE. If LOOP_LAT=0, skip DRAIN and go straight to DONE.
- DONE: uo_out=err_cnt, held there. A start edge restarts exactly as from IDLE.
- Patterns, by mode:
  - 00 counter: P(k)=k mod 2^WIDTH.
  - 01 walking one: P(k)=1<<(k mod WIDTH).
  - 10 LFSR: P(0)=LFSR_SEED, P(k+1)={P[WIDTH-2:0], ^(P & LFSR_TAPS)}.
  - 11 checkerboard: 0x55.. on even k, 0xAA.. on odd k.
- Check: P(k) is compared against uio_in sampled LOOP_LAT cycles after the cycle uo_out=P(k), using a valid-tagged delay line. Only valid samples are compared, so DRAIN completes the final LOOP_LAT comparisons.
- Mismatch on any bit increments err_cnt by 1 per cycle (not per bit). err_cnt saturates at all-ones (WIDTH bits).
- With check_en=0, no comparisons are made and err_cnt stays 0.
- Abort: ui_in[4]=1 in RUN or DRAIN goes to IDLE next cycle, uo_out=0, err_cnt cleared. Abort in IDLE/DONE has no effect.
- Abort takes priority over start in the same cycle.
- A start edge during RUN/DRAIN is ignored.
- mode and check_en changes are ignored except at the start edge.
- ui_in[7:5] are ignored.

Test Plan:
- Counter run: mode 00, check_en=1, bench loops uo_out->uio_in with 2-cycle delay, start pulse. uo_out must read 00,01,...,FF over 256 cycles, then 2 cycles of 00, then DONE with uo_out=00.
- Walking one and checkerboard: mode 01 must give 01,02,04,...,80,01,... Mode 11 must give 55,AA,55,...
- LFSR: mode 10 with defaults must give 01,02,04,08,11,... and P(255)=01 (period 255).
- Error injection: counter run with bit0 of uio_in flipped on 3 separate valid cycles -> DONE uo_out=03. Inverted loopback for the full run -> uo_out=FF (saturated, no wrap).
- Abort and reset: ui_in[4]=1 at k=100 -> IDLE, uo_out=00, a new start works. rst_n low mid-RUN -> uo_out=00 immediately (asynchronous, not waiting for a clock edge).
- ena gating: ena=0 for 10 cycles mid-run -> uo_out holds its value. The sequence resumes without skip, and the start edge is not re-detected.
